// File: rtl/bus_chain_initiator.sv
// Single-outstanding initiator at the head of the daisy-chained register bus.
// Launches one host request onto the chain and reports its return or a timeout.
module bus_chain_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req_addr_i,
    input  logic [15:0] req_wdata_i,
    input  logic        req_rw_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    output logic [15:0] addr_o,
    output logic [15:0] wdata_o,
    output logic [15:0] rdata_o,
    output logic        rw_o,
    output logic        valid_o,
    input  logic [15:0] addr_i,
    input  logic [15:0] wdata_i,
    input  logic [15:0] rdata_i,
    input  logic        rw_i,
    input  logic        valid_i,
    output logic [15:0] resp_rdata_o,
    output logic        resp_rw_o,
    output logic        resp_timeout_o,
    output logic        resp_valid_o,
    input  logic        resp_ready_i
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                rw_q, rw_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                resp_rw_q, resp_rw_d;
    logic                resp_timeout_q, resp_timeout_d;
    logic                resp_valid_q, resp_valid_d;
    logic                ready_q, ready_d;
    logic                match_c;
    logic                unused_tail;

    // Tail write data carries no information for the initiator.
    assign unused_tail = ^wdata_i;

    assign match_c = valid_i && (addr_i == addr_q) && (rw_i == rw_q);

    // Next-state and output logic.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rw_d           = rw_q;
        valid_d        = 1'b0;
        resp_rdata_d   = resp_rdata_q;
        resp_rw_d      = resp_rw_q;
        resp_timeout_d = resp_timeout_q;
        resp_valid_d   = resp_valid_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    rw_d    = req_rw_i;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE, S_WAIT: begin
                state_d = S_WAIT;
                // A match in the final counted cycle still beats the timeout.
                if (match_c) begin
                    resp_valid_d   = 1'b1;
                    resp_rdata_d   = rw_q ? DATA_W'(0) : rdata_i;
                    resp_rw_d      = rw_q;
                    resp_timeout_d = 1'b0;
                    state_d        = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    resp_valid_d   = 1'b1;
                    resp_rdata_d   = '0;
                    resp_rw_d      = rw_q;
                    resp_timeout_d = 1'b1;
                    state_d        = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rw_q           <= 1'b0;
            valid_q        <= 1'b0;
            resp_rdata_q   <= '0;
            resp_rw_q      <= 1'b0;
            resp_timeout_q <= 1'b0;
            resp_valid_q   <= 1'b0;
            ready_q        <= 1'b1;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            rw_q           <= rw_d;
            valid_q        <= valid_d;
            resp_rdata_q   <= resp_rdata_d;
            resp_rw_q      <= resp_rw_d;
            resp_timeout_q <= resp_timeout_d;
            resp_valid_q   <= resp_valid_d;
            ready_q        <= ready_d;
        end
    end

    assign req_ready_o    = ready_q;
    assign addr_o         = addr_q;
    assign wdata_o        = wdata_q;
    assign rdata_o        = '0;
    assign rw_o           = rw_q;
    assign valid_o        = valid_q;
    assign resp_rdata_o   = resp_rdata_q;
    assign resp_rw_o      = resp_rw_q;
    assign resp_timeout_o = resp_timeout_q;
    assign resp_valid_o   = resp_valid_q;

endmodule

// File: tb/tb_bus_chain_initiator.sv
// Bench for bus_chain_initiator: transaction-level model checked every cycle
// plus directed scenarios with literal expectations.
module tb_bus_chain_initiator;

    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic        req_rw = 1'b0, req_valid = 1'b0, req_ready;
    logic [15:0] addr_o, wdata_o, rdata_o;
    logic        rw_o, valid_o;
    logic [15:0] resp_rdata;
    logic        resp_rw, resp_timeout, resp_valid;
    logic        resp_ready = 1'b0;

    logic        loop_en = 1'b0;
    logic        t_valid = 1'b0, t_rw = 1'b0;
    logic [15:0] t_addr = '0, t_rdata = '0;
    logic [15:0] addr_i, wdata_i, rdata_i;
    logic        rw_i, valid_i;

    // Chain tail: either a directed driver or a zero-delay loopback of the head.
    assign valid_i = loop_en ? valid_o : t_valid;
    assign addr_i  = loop_en ? addr_o  : t_addr;
    assign wdata_i = loop_en ? wdata_o : 16'h0;
    assign rdata_i = loop_en ? rdata_o : t_rdata;
    assign rw_i    = loop_en ? rw_o    : t_rw;

    always #5 clk = ~clk;

    bus_chain_initiator #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_rw_i(req_rw),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .addr_o(addr_o), .wdata_o(wdata_o), .rdata_o(rdata_o), .rw_o(rw_o),
        .valid_o(valid_o),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i), .rw_i(rw_i),
        .valid_i(valid_i),
        .resp_rdata_o(resp_rdata), .resp_rw_o(resp_rw),
        .resp_timeout_o(resp_timeout), .resp_valid_o(resp_valid),
        .resp_ready_i(resp_ready)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a request accepted at cycle m_req is launched at m_req+1; the first
    // matching tail beat in m_req+1..m_req+T (or the end of that window) fixes
    // the cycle m_rise at which the response appears.
    logic        m_busy;
    int          m_req, m_rise;
    logic [15:0] m_addr, m_wdata, m_rdata;
    logic        m_rw, m_rrw, m_to;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_req   <= -10;
            m_rise  <= -1;
            m_addr  <= '0;
            m_wdata <= '0;
            m_rw    <= 1'b0;
            m_rdata <= '0;
            m_rrw   <= 1'b0;
            m_to    <= 1'b0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy  <= 1'b1;
                m_req   <= cyc;
                m_rise  <= -1;
                m_addr  <= req_addr;
                m_wdata <= req_wdata;
                m_rw    <= req_rw;
            end
        end else if (m_rise < 0) begin
            if (valid_i && addr_i == m_addr && rw_i == m_rw) begin
                m_rise  <= cyc + 1;
                m_rdata <= m_rw ? 16'h0 : rdata_i;
                m_rrw   <= m_rw;
                m_to    <= 1'b0;
            end else if (cyc == m_req + int'(T)) begin
                m_rise  <= cyc + 1;
                m_rdata <= 16'h0;
                m_rrw   <= m_rw;
                m_to    <= 1'b1;
            end
        end else if (cyc >= m_rise && resp_ready) begin
            m_busy <= 1'b0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("req_ready", 32'(req_ready), 32'(!m_busy));
            chk("valid_o", 32'(valid_o), 32'(m_busy && cyc == m_req + 1));
            chk("addr_o", 32'(addr_o), 32'(m_addr));
            chk("wdata_o", 32'(wdata_o), 32'(m_wdata));
            chk("rw_o", 32'(rw_o), 32'(m_rw));
            chk("rdata_o", 32'(rdata_o), 32'h0);
            chk("resp_valid", 32'(resp_valid), 32'(m_busy && m_rise >= 0 && cyc >= m_rise));
            chk("resp_rdata", 32'(resp_rdata), 32'(m_rdata));
            chk("resp_rw", 32'(resp_rw), 32'(m_rrw));
            chk("resp_timeout", 32'(resp_timeout), 32'(m_to));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [15:0] a, input logic [15:0] d, input logic rw);
        req_addr  = a;
        req_wdata = d;
        req_rw    = rw;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic tail(input logic v, input logic [15:0] a, input logic rw, input logic [15:0] rd);
        t_valid = v;
        t_addr  = a;
        t_rw    = rw;
        t_rdata = rd;
    endtask

    task automatic ack();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid_o", 32'(valid_o), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        #9 rst_n = 1'b1;
        step();
        step();

        // Read over a 3-cycle chain loop; return lands in the last timeout cycle.
        drive_req(16'h0002, 16'h0000, 1'b0);
        chk("rd_pulse", 32'(valid_o), 32'h1);
        chk("rd_addr", 32'(addr_o), 32'h0002);
        step();
        chk("rd_pulse_end", 32'(valid_o), 32'h0);
        chk("rd_busy", 32'(req_ready), 32'h0);
        step();
        step();
        tail(1'b1, 16'h0002, 1'b0, 16'h1234);
        step();
        tail(1'b0, 16'h0, 1'b0, 16'h0);
        chk("rd_resp_valid", 32'(resp_valid), 32'h1);
        chk("rd_resp_rdata", 32'(resp_rdata), 32'h1234);
        chk("rd_resp_to", 32'(resp_timeout), 32'h0);
        ack();
        chk("rd_resp_drop", 32'(resp_valid), 32'h0);
        chk("rd_ready_back", 32'(req_ready), 32'h1);

        // Write: response reports rw=1 and zero data.
        drive_req(16'h0001, 16'hFFF0, 1'b1);
        chk("wr_wdata", 32'(wdata_o), 32'hFFF0);
        chk("wr_rw", 32'(rw_o), 32'h1);
        step();
        tail(1'b1, 16'h0001, 1'b1, 16'hAAAA);
        step();
        tail(1'b0, 16'h0, 1'b0, 16'h0);
        chk("wr_resp_valid", 32'(resp_valid), 32'h1);
        chk("wr_resp_rw", 32'(resp_rw), 32'h1);
        chk("wr_resp_rdata", 32'(resp_rdata), 32'h0);
        ack();

        // Timeout with a stalled transmitter and late returns.
        drive_req(16'h0007, 16'h0000, 1'b0);
        step();
        step();
        step();
        chk("to_not_yet", 32'(resp_valid), 32'h0);
        step();
        chk("to_resp_valid", 32'(resp_valid), 32'h1);
        chk("to_flag", 32'(resp_timeout), 32'h1);
        chk("to_rdata", 32'(resp_rdata), 32'h0);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) tail(1'b1, 16'h0007, 1'b0, 16'h5555);
            step();
            tail(1'b0, 16'h0, 1'b0, 16'h0);
            chk("to_stall_ready", 32'(req_ready), 32'h0);
            chk("to_stall_flag", 32'(resp_timeout), 32'h1);
        end
        ack();
        chk("to_ready_back", 32'(req_ready), 32'h1);
        tail(1'b1, 16'h0007, 1'b0, 16'h5555);
        step();
        tail(1'b0, 16'h0, 1'b0, 16'h0);
        chk("to_late_ignored", 32'(resp_valid), 32'h0);
        chk("to_keep_flag", 32'(resp_timeout), 32'h1);

        // Decoy tail traffic, genuine return in the final timeout cycle.
        drive_req(16'h0003, 16'h0000, 1'b0);
        tail(1'b1, 16'h0005, 1'b0, 16'h1111);
        step();
        tail(1'b1, 16'h0003, 1'b1, 16'h2222);
        step();
        tail(1'b0, 16'h0, 1'b0, 16'h0);
        step();
        tail(1'b1, 16'h0003, 1'b0, 16'hBEEF);
        step();
        tail(1'b0, 16'h0, 1'b0, 16'h0);
        chk("dc_resp_valid", 32'(resp_valid), 32'h1);
        chk("dc_rdata", 32'(resp_rdata), 32'hBEEF);
        chk("dc_to", 32'(resp_timeout), 32'h0);
        ack();

        // Back-to-back requests over a zero-delay loopback.
        loop_en = 1'b1;
        drive_req(16'h0009, 16'h0055, 1'b1);
        step();
        chk("bb1_resp_valid", 32'(resp_valid), 32'h1);
        chk("bb1_rw", 32'(resp_rw), 32'h1);
        resp_ready = 1'b1;
        step();
        chk("bb_ready", 32'(req_ready), 32'h1);
        drive_req(16'h000A, 16'h0000, 1'b0);
        step();
        chk("bb2_resp_valid", 32'(resp_valid), 32'h1);
        chk("bb2_rw", 32'(resp_rw), 32'h0);
        chk("bb2_to", 32'(resp_timeout), 32'h0);
        step();
        resp_ready = 1'b0;
        loop_en = 1'b0;
        chk("bb2_done", 32'(resp_valid), 32'h0);

        // Asynchronous reset during WAIT.
        drive_req(16'h0004, 16'h0000, 1'b0);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_addr", 32'(addr_o), 32'h0);
        chk("ar_valid_o", 32'(valid_o), 32'h0);
        chk("ar_resp", 32'({resp_valid, resp_timeout, resp_rw, resp_rdata}), 32'h0);
        chk("ar_ready", 32'(req_ready), 32'h1);
        #2 rst_n = 1'b1;
        step();
        tail(1'b1, 16'h0004, 1'b0, 16'h9999);
        step();
        tail(1'b0, 16'h0, 1'b0, 16'h0);
        chk("ar_stale", 32'(resp_valid), 32'h0);
        chk("ar_ready_after", 32'(req_ready), 32'h1);
        drive_req(16'h0004, 16'h0000, 1'b0);
        step();
        tail(1'b1, 16'h0004, 1'b0, 16'h4242);
        step();
        tail(1'b0, 16'h0, 1'b0, 16'h0);
        chk("ar_next_valid", 32'(resp_valid), 32'h1);
        chk("ar_next_rdata", 32'(resp_rdata), 32'h4242);
        ack();
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
